// File: rtl/eep_arbiter.sv
// Arbitrates the single EEPROM port between the PID coefficient loader (read-only)
// and the UART command interpreter (read/write), and drives the EEPROM pins.
module eep_arbiter #(
  parameter logic [21:0] WRT_CYCLES = 22'h249F00,
  parameter int          DW         = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pid_req,
  input  logic [1:0]    pid_addr,
  output logic          pid_gnt,
  output logic          pid_vld,
  input  logic          cmd_req,
  input  logic          cmd_wr,
  input  logic [1:0]    cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          cmd_gnt,
  output logic          cmd_done,
  output logic [DW-1:0] rd_data,
  input  logic [DW-1:0] eep_rdata,
  output logic [1:0]    eep_addr,
  output logic [DW-1:0] eep_wdata,
  output logic          eep_cs_n,
  output logic          eep_r_w_n,
  output logic          chrg_pmp_en,
  output logic          busy
);

  localparam int CNT_W = $clog2({1'b0, WRT_CYCLES} + 23'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WRT_CYCLES - 22'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t          state_r;
  logic [CNT_W-1:0] wcnt_r;
  logic             last_pid_r;
  logic [1:0]       addr_r;
  logic [DW-1:0]    wdata_r;
  logic             pick_pid_s;
  logic             pick_cmd_s;

  assign eep_addr  = addr_r;
  assign eep_wdata = wdata_r;

  // Fixed PID priority, except cmd wins right after a PID grant so it cannot starve.
  always_comb begin
    pick_pid_s = 1'b0;
    pick_cmd_s = 1'b0;
    if (cmd_req && (last_pid_r || !pid_req)) begin
      pick_cmd_s = 1'b1;
    end else if (pid_req) begin
      pick_pid_s = 1'b1;
    end else begin
      pick_pid_s = 1'b0;
    end
  end

  // Access sequencer: pins, pulses and read data are all registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      wcnt_r      <= '0;
      last_pid_r  <= 1'b0;
      addr_r      <= 2'b00;
      wdata_r     <= '0;
      rd_data     <= '0;
      pid_gnt     <= 1'b0;
      pid_vld     <= 1'b0;
      cmd_gnt     <= 1'b0;
      cmd_done    <= 1'b0;
      eep_cs_n    <= 1'b1;
      eep_r_w_n   <= 1'b1;
      chrg_pmp_en <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pid_gnt  <= 1'b0;
      pid_vld  <= 1'b0;
      cmd_gnt  <= 1'b0;
      cmd_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_pid_s) begin
            state_r    <= RD;
            last_pid_r <= 1'b1;
            addr_r     <= pid_addr;
            wdata_r    <= '0;
            pid_gnt    <= 1'b1;
            eep_cs_n   <= 1'b0;
            eep_r_w_n  <= 1'b1;
            busy       <= 1'b1;
          end else if (pick_cmd_s) begin
            last_pid_r <= 1'b0;
            addr_r     <= cmd_addr;
            wdata_r    <= cmd_wdata;
            cmd_gnt    <= 1'b1;
            eep_cs_n   <= 1'b0;
            busy       <= 1'b1;
            if (cmd_wr) begin
              state_r     <= WR;
              wcnt_r      <= '0;
              eep_r_w_n   <= 1'b0;
              chrg_pmp_en <= 1'b1;
            end else begin
              state_r     <= RD;
              eep_r_w_n   <= 1'b1;
              chrg_pmp_en <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          rd_data   <= eep_rdata;
          state_r   <= IDLE;
          eep_cs_n  <= 1'b1;
          eep_r_w_n <= 1'b1;
          busy      <= 1'b0;
          pid_vld   <= last_pid_r;
          cmd_done  <= !last_pid_r;
        end
        WR: begin
          if (wcnt_r == CNT_LAST) begin
            state_r     <= IDLE;
            eep_cs_n    <= 1'b1;
            eep_r_w_n   <= 1'b1;
            chrg_pmp_en <= 1'b0;
            busy        <= 1'b0;
            cmd_done    <= 1'b1;
          end else begin
            wcnt_r <= wcnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          eep_cs_n    <= 1'b1;
          eep_r_w_n   <= 1'b1;
          chrg_pmp_en <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/eep_arbiter.md
# eep_arbiter

Shares the single EEPROM port between the PID coefficient loader, which only reads, and the UART command interpreter, which reads and writes. It sequences each access and drives the EEPROM control pins, including the charge-pump hold for writes. It registers the read data and returns a completion pulse to whichever requester was served. It sits between the control state machine and the EEPROM macro and replaces direct pin driving from the controller.

## Interface
Parameters:
- WRT_CYCLES, default 22'h249F00, number of cycles a write holds cs_n/r_w_n low with the charge pump enabled (3 ms at system clock).
- DW, default 14, EEPROM data width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pid_req  in  1  PID loader read request; level, held until pid_gnt.
- pid_addr  in  2  PID read address.
- pid_gnt  out  1  one-cycle pulse; PID access cycle in progress.
- pid_vld  out  1  one-cycle pulse; rd_data holds PID result.
- cmd_req  in  1  command request; level, held until cmd_gnt.
- cmd_wr  in  1  1 = write, 0 = read; sampled with cmd_req.
- cmd_addr  in  2  command address.
- cmd_wdata  in  DW  command write data.
- cmd_gnt  out  1  one-cycle pulse; command access started.
- cmd_done  out  1  one-cycle pulse; command read data valid, or write complete.
- rd_data  out  DW  registered read data.
- eep_rdata  in  DW  EEPROM read data, valid during the access cycle.
- eep_addr  out  2  EEPROM address.
- eep_wdata  out  DW  EEPROM write data.
- eep_cs_n  out  1  chip select, active low.
- eep_r_w_n  out  1  1 = read, 0 = write.
- chrg_pmp_en  out  1  charge pump enable, writes only.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RD, WR.
- IDLE: every EEPROM pin is deasserted (cs_n=1, r_w_n=1, chrg_pmp_en=0).
- IDLE arbitration:
  - Fixed priority to PID.
  - Exception: if the previous grant went to PID and cmd_req is high, cmd wins. This prevents command starvation.
  - The winner's addr, wr and wdata are latched into internal registers; eep_addr and eep_wdata drive from these registers.
- IDLE → RD: winner is PID, or winner is cmd with cmd_wr=0.
- IDLE → WR: winner is cmd with cmd_wr=1. The write counter clears on entry.
- RD (exactly 1 cycle):
  - cs_n=0, r_w_n=1, gnt pulse to the owner.
  - rd_data <= eep_rdata at the end of the cycle.
  - → IDLE.
- WR (WRT_CYCLES cycles):
  - cs_n=0, r_w_n=0, chrg_pmp_en=1, cmd_gnt pulsed in the first WR cycle only.
  - The counter increments each cycle. At count = WRT_CYCLES-1 the state returns to IDLE.
  - rd_data is unchanged.
- Completion: pid_vld or cmd_done pulses in the first IDLE cycle after RD or WR. This pulse may coincide with a new arbitration in the same cycle.
- Counter width: ceil(log2(WRT_CYCLES+1)). WRT_CYCLES=1 gives a single write cycle.
- The owner flag records the last grant and is used by both arbitration and completion routing.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: eep_cs_n=1, eep_r_w_n=1, chrg_pmp_en=0, eep_addr=0, eep_wdata=0, rd_data=0, all gnt/vld/done=0, busy=0.
  - Internal: state=IDLE, last-grant=cmd, so PID wins the first tie.
- Reset during WR aborts the write immediately; cmd_done is not issued.
- Read latency: request seen in IDLE at cycle N → RD at N+1 (gnt high) → vld/done at N+2.
- Write latency: request at N → WR during N+1 .. N+WRT_CYCLES → cmd_done at N+WRT_CYCLES+1.
- Requesters drop req on the edge after gnt. A req still high in the IDLE cycle after completion is treated as a new request.
- A request that arrives while busy is held, not lost. Only requests present in IDLE are arbitrated.
- A requester may withdraw req before gnt with no side effect.
- Changes to cmd_addr or cmd_wdata after the grant decision do not affect eep_addr or eep_wdata.
- Back-to-back accesses: minimum two cycles per read; IDLE is always visited between accesses.

## Test plan
- After reset: pid_req=1, pid_addr=2'b01, eep_rdata=14'h0123 → RD one cycle later with eep_addr=01, cs_n=0, r_w_n=1; next cycle pid_vld=1, rd_data=14'h0123.
- With WRT_CYCLES=8: cmd_req=1, cmd_wr=1, cmd_addr=2'b10, cmd_wdata=14'h1ABC → cs_n=0, r_w_n=0, chrg_pmp_en=1, eep_wdata=14'h1ABC for exactly 8 cycles, then cmd_done pulse, pins deasserted.
- pid_req and cmd_req (read) asserted together from reset → PID granted first, cmd granted on the next IDLE. With both held continuously, grants alternate PID, cmd, PID.
- pid_req rises during a cmd write → no PID access until cmd_done; PID RD follows in the cycle after cmd_done.
- rst pulsed in the 4th WR cycle → cs_n=1, chrg_pmp_en=0 immediately, no cmd_done, busy=0. A fresh write afterward runs the full 8 cycles.
